// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the pool-stage feeder and its bench
package cnn_pkg;
   localparam int CNN_DATA_WIDTH = 16;
   localparam int BEAT_TL = 0;
   localparam int BEAT_TR = 1;
   localparam int BEAT_BL = 2;
   localparam int BEAT_BR = 3;
   typedef enum logic [2:0] {ACCEPT, EMIT0, EMIT1, EMIT2, EMIT3, CLEAR} pool_state_t;
endpackage

// File: rtl/pool_window_sequencer_if.sv
// pool_window_sequencer_if: pixel input handshake plus pool-stage drive bundle
interface pool_window_sequencer_if
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         pool_run;
   logic                         pool_clear;
   logic signed [DATA_WIDTH-1:0] pool_data;
   logic                         frame_done;
   modport master (output in_valid, in_data, input in_ready, pool_run, pool_clear, pool_data, frame_done);
   modport slave  (input in_valid, in_data, output in_ready, pool_run, pool_clear, pool_data, frame_done);
endinterface

// File: rtl/pool_window_sequencer_line_buffer.sv
// line_buffer: one-row store, single write port, two combinational read ports
module line_buffer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int DEPTH      = 28,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         we_i,
   input  logic [AW-1:0]                wa_i,
   input  logic signed [DATA_WIDTH-1:0] wd_i,
   input  logic [AW-1:0]                ra0_i,
   input  logic [AW-1:0]                ra1_i,
   output logic signed [DATA_WIDTH-1:0] rd0_o,
   output logic signed [DATA_WIDTH-1:0] rd1_o
);
   logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
   // contents are never reset: every entry is rewritten on the even row before it is read
   always_ff @(posedge clk)
      if (we_i) mem_q[wa_i] <= wd_i;
   assign rd0_o = mem_q[ra0_i];
   assign rd1_o = mem_q[ra1_i];
endmodule

// File: rtl/pool_window_sequencer.sv
// pool_window_sequencer: buffers an even row and replays each 2x2 window as four run beats plus a clear
module pool_window_sequencer
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input logic                    clk,
   input logic                    reset_n,
   input logic                    flush,
   pool_window_sequencer_if.slave bus
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   if (IMG_WIDTH < 2 || IMG_WIDTH % 2 != 0) begin : g_bad_width
      $error("IMG_WIDTH must be even and >= 2");
   end
   if (IMG_HEIGHT < 2 || IMG_HEIGHT % 2 != 0) begin : g_bad_height
      $error("IMG_HEIGHT must be even and >= 2");
   end
   pool_state_t                  state_q;
   logic [CW-1:0]                col_q, col_d, win_col_q, tl_addr;
   logic [RW-1:0]                row_q, row_d;
   logic signed [DATA_WIDTH-1:0] left_q, right_q, data_q, top_left, top_right;
   logic                         last_q, run_q, clr_q, done_q;
   logic                         accept, lb_we, col_end, row_end;
   assign accept  = state_q == ACCEPT && bus.in_valid;
   assign lb_we   = accept && !flush && !row_q[0];
   assign tl_addr = col_q - 1'b1;
   // raster position of the pixel after the one being accepted
   always_comb begin
      col_end = col_q == CW'(IMG_WIDTH - 1);
      row_end = row_q == RW'(IMG_HEIGHT - 1);
      col_d   = col_end ? '0 : col_q + 1'b1;
      row_d   = !col_end ? row_q : row_end ? '0 : row_q + 1'b1;
   end
   line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMG_WIDTH)
   ) u_lb (
      .clk  (clk),
      .we_i (lb_we),
      .wa_i (col_q),
      .wd_i (bus.in_data),
      .ra0_i(tl_addr),
      .ra1_i(win_col_q),
      .rd0_o(top_left),
      .rd1_o(top_right)
   );
   // window FSM; each output register is loaded with the value for the state being entered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ACCEPT;
         row_q     <= '0;
         col_q     <= '0;
         win_col_q <= '0;
         left_q    <= '0;
         right_q   <= '0;
         last_q    <= 1'b0;
         run_q     <= 1'b0;
         clr_q     <= 1'b0;
         done_q    <= 1'b0;
         data_q    <= '0;
      end else if (flush) begin
         state_q <= ACCEPT;
         row_q   <= '0;
         col_q   <= '0;
         run_q   <= 1'b0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         run_q  <= 1'b0;
         clr_q  <= 1'b0;
         done_q <= 1'b0;
         data_q <= '0;
         case (state_q)
            ACCEPT: if (bus.in_valid) begin
               col_q <= col_d;
               row_q <= row_d;
               if (row_q[0] && !col_q[0]) left_q <= bus.in_data;
               if (row_q[0] && col_q[0]) begin
                  right_q   <= bus.in_data;
                  win_col_q <= col_q;
                  last_q    <= row_end && col_end;
                  state_q   <= EMIT0;
                  run_q     <= 1'b1;
                  data_q    <= top_left;
               end
            end
            EMIT0: begin
               state_q <= EMIT1;
               run_q   <= 1'b1;
               data_q  <= top_right;
            end
            EMIT1: begin
               state_q <= EMIT2;
               run_q   <= 1'b1;
               data_q  <= left_q;
            end
            EMIT2: begin
               state_q <= EMIT3;
               run_q   <= 1'b1;
               data_q  <= right_q;
            end
            EMIT3: begin
               state_q <= CLEAR;
               clr_q   <= 1'b1;
            end
            CLEAR: begin
               state_q <= ACCEPT;
               done_q  <= last_q;
            end
            default: state_q <= ACCEPT;
         endcase
      end
   end
   assign bus.in_ready   = reset_n && state_q == ACCEPT;
   assign bus.pool_run   = run_q;
   assign bus.pool_clear = clr_q;
   assign bus.pool_data  = data_q;
   assign bus.frame_done = done_q;
endmodule
